// File: rtl/cal_exe_sched.sv
// EXE-phase scheduler: converts BCD operands, starts one arithmetic unit, collects its result.
// Optional watchdog in WAIT is enabled by defining CAL_EXE_TIMEOUT_EN.
module cal_exe_sched #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned OPD_W     = 11,
  parameter int unsigned RES_W     = 24,
  parameter int unsigned TMO_CYC   = 1023
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          exe_start_i,
  input  logic [NUM_UNITS-1:0]          op_sel_i,
  input  logic [11:0]                   a_bcd_i,
  input  logic                          a_sign_i,
  input  logic [11:0]                   b_bcd_i,
  input  logic                          b_sign_i,
  output logic signed [OPD_W-1:0]       op_a_o,
  output logic signed [OPD_W-1:0]       op_b_o,
  output logic [NUM_UNITS-1:0]          unit_start_o,
  input  logic [NUM_UNITS-1:0]          unit_done_i,
  input  logic [NUM_UNITS*RES_W-1:0]    unit_result_i,
  input  logic [NUM_UNITS-1:0]          unit_err_i,
  output logic                          busy_o,
  output logic                          exe_done_o,
  output logic signed [RES_W-1:0]       result_o,
  output logic [1:0]                    err_code_o
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned MAG_W = 10;
  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_BADOP = 2'b01;
  localparam logic [1:0] ERR_UNIT  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CONV  = 5'b00010,
    ST_ISSUE = 5'b00100,
    ST_WAIT  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_UNITS-1:0]     op_sel_q, op_sel_d;
  logic [BCD_W-1:0]         a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
  logic                     a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic signed [OPD_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [NUM_UNITS-1:0]     unit_start_q, unit_start_d;
  logic                     busy_q, busy_d, exe_done_q, exe_done_d;
  logic signed [RES_W-1:0]  result_q, result_d;
  logic [1:0]               err_q, err_d;

  logic                     sel_ok_c, done_hit_c, err_hit_c, tmo_hit_c;
  logic [RES_W-1:0]         sel_result_c;

  // Saturating BCD-to-signed conversion; negative zero collapses to zero naturally.
  function automatic logic [OPD_W-1:0] bcd_to_opd(input logic [BCD_W-1:0] bcd, input logic neg);
    logic [MAG_W-1:0] mag;
    logic [3:0]       dig;
    logic [OPD_W-1:0] opd;
    mag = '0;
    for (int i = 2; i >= 0; i--) begin
      dig = (bcd[i*4 +: 4] > 4'd9) ? 4'd9 : bcd[i*4 +: 4];
      mag = MAG_W'(mag * MAG_W'(10)) + MAG_W'(dig);
    end
    opd = OPD_W'(mag);
    return neg ? -opd : opd;
  endfunction

  assign sel_ok_c   = (op_sel_q != '0) && ((op_sel_q & (op_sel_q - NUM_UNITS'(1))) == '0);
  assign done_hit_c = |(unit_done_i & op_sel_q);
  assign err_hit_c  = |(unit_err_i & unit_done_i & op_sel_q);

  always_comb begin
    sel_result_c = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (op_sel_q[i]) sel_result_c = sel_result_c | unit_result_i[i*RES_W +: RES_W];
    end
  end

`ifdef CAL_EXE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit_c = (cnt_q == CNT_W'(TMO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_ISSUE)     cnt_d = '0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo_c;
  assign tmo_hit_c    = 1'b0;
  assign unused_tmo_c = ^(CNT_W'(TMO_CYC));
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (exe_start_i) state_d = ST_CONV;
      ST_CONV:  state_d = sel_ok_c ? ST_ISSUE : ST_DONE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done_hit_c || tmo_hit_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; flags follow the state being entered
  always_comb begin
    op_sel_d     = op_sel_q;
    a_bcd_d      = a_bcd_q;
    a_sign_d     = a_sign_q;
    b_bcd_d      = b_bcd_q;
    b_sign_d     = b_sign_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    err_d        = err_q;
    unit_start_d = (state_d == ST_ISSUE) ? op_sel_q : '0;
    busy_d       = (state_d != ST_IDLE);
    exe_done_d   = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (exe_start_i) begin
          op_sel_d = op_sel_i;
          a_bcd_d  = a_bcd_i;
          a_sign_d = a_sign_i;
          b_bcd_d  = b_bcd_i;
          b_sign_d = b_sign_i;
        end
      end
      ST_CONV: begin
        op_a_d = bcd_to_opd(a_bcd_q, a_sign_q);
        op_b_d = bcd_to_opd(b_bcd_q, b_sign_q);
        if (!sel_ok_c) begin
          err_d    = ERR_BADOP;
          result_d = '0;
        end
      end
      ST_WAIT: begin
        if (done_hit_c) begin
          err_d    = err_hit_c ? ERR_UNIT : ERR_OK;
          result_d = err_hit_c ? '0 : sel_result_c;
        end else if (tmo_hit_c) begin
          err_d    = ERR_TMO;
          result_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_sel_q     <= '0;
      a_bcd_q      <= '0;
      a_sign_q     <= 1'b0;
      b_bcd_q      <= '0;
      b_sign_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      unit_start_q <= '0;
      busy_q       <= 1'b0;
      exe_done_q   <= 1'b0;
      result_q     <= '0;
      err_q        <= '0;
    end else begin
      op_sel_q     <= op_sel_d;
      a_bcd_q      <= a_bcd_d;
      a_sign_q     <= a_sign_d;
      b_bcd_q      <= b_bcd_d;
      b_sign_q     <= b_sign_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      unit_start_q <= unit_start_d;
      busy_q       <= busy_d;
      exe_done_q   <= exe_done_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign unit_start_o = unit_start_q;
  assign busy_o       = busy_q;
  assign exe_done_o   = exe_done_q;
  assign result_o     = result_q;
  assign err_code_o   = err_q;

endmodule

// File: tb/tb_cal_exe_sched.sv
// Bench for cal_exe_sched: vector table (hand + random with a reference model) and corner sequences.
// Timeout expectations follow CAL_EXE_TIMEOUT_EN when it is defined for the build.
module tb_cal_exe_sched;

  localparam int NU    = 4;
  localparam int OPD_W = 11;
  localparam int RES_W = 24;
  localparam int TMO   = 8;
  localparam int MAXC  = 40;

  logic                     clk_i;
  logic                     rst_i;
  logic                     exe_start_i;
  logic [NU-1:0]            op_sel_i;
  logic [11:0]              a_bcd_i, b_bcd_i;
  logic                     a_sign_i, b_sign_i;
  logic signed [OPD_W-1:0]  op_a_o, op_b_o;
  logic [NU-1:0]            unit_start_o;
  logic [NU-1:0]            unit_done_i;
  logic [NU*RES_W-1:0]      unit_result_i;
  logic [NU-1:0]            unit_err_i;
  logic                     busy_o, exe_done_o;
  logic signed [RES_W-1:0]  result_o;
  logic [1:0]               err_code_o;

  cal_exe_sched #(.NUM_UNITS(NU), .OPD_W(OPD_W), .RES_W(RES_W), .TMO_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .exe_start_i(exe_start_i), .op_sel_i(op_sel_i),
    .a_bcd_i(a_bcd_i), .a_sign_i(a_sign_i), .b_bcd_i(b_bcd_i), .b_sign_i(b_sign_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .unit_start_o(unit_start_o),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i), .unit_err_i(unit_err_i),
    .busy_o(busy_o), .exe_done_o(exe_done_o), .result_o(result_o), .err_code_o(err_code_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] a_bcd;
    bit          a_sign;
    logic [11:0] b_bcd;
    bit          b_sign;
    logic [3:0]  op_sel;
    int          lat;
    int          res;
    bit          uerr;
    bit          stray;
    int          e_opa;
    int          e_opb;
    logic [3:0]  e_start;
    int          e_done;
    int          e_err;
    int          e_res;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [11:0] a, input bit as, input logic [11:0] b,
                                  input bit bs, input logic [3:0] op, input int lat, input int res,
                                  input bit uerr, input bit stray, input int eopa, input int eopb,
                                  input logic [3:0] estart, input int edone, input int eerr,
                                  input int eres);
    vec_t v;
    v.a_bcd = a; v.a_sign = as; v.b_bcd = b; v.b_sign = bs; v.op_sel = op;
    v.lat = lat; v.res = res; v.uerr = uerr; v.stray = stray;
    v.e_opa = eopa; v.e_opb = eopb; v.e_start = estart; v.e_done = edone;
    v.e_err = eerr; v.e_res = eres;
    tbl.push_back(v);
  endfunction

  // Reference: decimal value of the digits (each clipped at 9), then apply the sign.
  function automatic int m_opd(input logic [11:0] bcd, input bit neg);
    int mag = 0;
    int d;
    for (int i = 2; i >= 0; i--) begin
      d = int'(bcd[i*4 +: 4]);
      if (d > 9) d = 9;
      mag = mag * 10 + d;
    end
    return neg ? -mag : mag;
  endfunction

  function automatic vec_t m_expect(input vec_t v);
    vec_t r = v;
    bit ok = ($countones(v.op_sel) == 1);
    r.e_opa   = m_opd(v.a_bcd, v.a_sign);
    r.e_opb   = m_opd(v.b_bcd, v.b_sign);
    r.e_start = ok ? v.op_sel : 4'b0000;
    r.e_done  = ok ? 3 + v.lat : 2;
    r.e_err   = !ok ? 1 : (v.uerr ? 2 : 0);
    r.e_res   = (!ok || v.uerr) ? 0 : v.res;
    return r;
  endfunction

  task automatic idle_inputs();
    exe_start_i = 1'b0;
    unit_done_i = '0;
    unit_err_i  = '0;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int opa2 = 0, opb2 = 0, st_cyc = -1, st_cnt = 0, dn_cyc = -1, dn_cnt = 0;
    int res_at = 0, err_at = -1, busy_bad = 0, sidx = 0;
    logic [3:0] st_val = '0;
    for (int u = 0; u < NU; u++) if (v.e_start[u]) sidx = u;
    for (int k = 0; k <= MAXC; k++) begin
      if (k == 0) begin
        a_bcd_i = v.a_bcd; a_sign_i = v.a_sign; b_bcd_i = v.b_bcd; b_sign_i = v.b_sign;
        op_sel_i = v.op_sel;
      end else begin
        a_bcd_i = 12'($urandom); a_sign_i = 1'($urandom); b_bcd_i = 12'($urandom);
        b_sign_i = 1'($urandom); op_sel_i = 4'($urandom);
      end
      exe_start_i = (k == 0) || (v.stray && k == 4);
      for (int u = 0; u < NU; u++) unit_result_i[u*RES_W +: RES_W] = RES_W'($urandom);
      unit_err_i  = 4'($urandom);
      unit_done_i = '0;
      if (v.stray && k == 2) unit_done_i = v.op_sel;
      if (v.stray && k == 3) unit_done_i = 4'b0010;
      if (v.e_start != 0 && k == 2 + v.lat) begin
        unit_done_i = v.e_start;
        unit_result_i[sidx*RES_W +: RES_W] = RES_W'(v.res);
        unit_err_i[sidx] = v.uerr;
      end
      @(negedge clk_i);
      if (k == 2) begin
        opa2 = int'(op_a_o);
        opb2 = int'(op_b_o);
      end
      if (unit_start_o != '0) begin
        st_cnt++;
        if (st_cyc < 0) begin st_cyc = k; st_val = unit_start_o; end
      end
      if (exe_done_o) begin
        dn_cnt++;
        if (dn_cyc < 0) begin dn_cyc = k; res_at = int'(result_o); err_at = int'(err_code_o); end
      end
      if (busy_o !== ((k >= 1) && (k <= v.e_done))) busy_bad++;
      @(posedge clk_i); #1;
      if (dn_cyc >= 0 && k == dn_cyc + 1) break;
    end
    idle_inputs();
    check($sformatf("v%0d op_a", idx), opa2, v.e_opa);
    check($sformatf("v%0d op_b", idx), opb2, v.e_opb);
    check($sformatf("v%0d unit_start value", idx), int'(st_val), int'(v.e_start));
    check($sformatf("v%0d unit_start pulses", idx), st_cnt, (v.e_start != 0) ? 1 : 0);
    check($sformatf("v%0d unit_start cycle", idx), st_cyc, (v.e_start != 0) ? 2 : -1);
    check($sformatf("v%0d exe_done cycle", idx), dn_cyc, v.e_done);
    check($sformatf("v%0d exe_done pulses", idx), dn_cnt, 1);
    check($sformatf("v%0d result", idx), res_at, v.e_res);
    check($sformatf("v%0d err_code", idx), err_at, v.e_err);
    check($sformatf("v%0d busy profile", idx), busy_bad, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    a_bcd_i = '0; a_sign_i = 1'b0; b_bcd_i = '0; b_sign_i = 1'b0; op_sel_i = '0;
    unit_result_i = '0;
    idle_inputs();

    // Hand-written vectors with constant expectations
    add_vec(12'h123, 0, 12'h045, 1, 4'b0001, 2, 78,       0, 0,  123,  -45, 4'b0001, 5, 0, 78);
    add_vec(12'h999, 1, 12'h001, 0, 4'b0000, 1, 55,       0, 0, -999,    1, 4'b0000, 2, 1, 0);
    add_vec(12'h010, 0, 12'h200, 1, 4'b0101, 1, 55,       0, 0,   10, -200, 4'b0000, 2, 1, 0);
    add_vec(12'h000, 1, 12'h007, 0, 4'b1000, 3, 1193046,  1, 0,    0,    7, 4'b1000, 6, 2, 0);
    add_vec(12'h500, 1, 12'h099, 0, 4'b0100, 4, -5,       0, 1, -500,   99, 4'b0100, 7, 0, -5);
    add_vec(12'hFAF, 1, 12'h9A0, 0, 4'b0010, 1, 8388607,  0, 0, -999,  990, 4'b0010, 4, 0, 8388607);
    add_vec(12'h001, 0, 12'h001, 0, 4'b1111, 1, 0,        0, 0,    1,    1, 4'b0000, 2, 1, 0);
    add_vec(12'h808, 0, 12'h070, 1, 4'b0001, 6, -8388608, 0, 0,  808,  -70, 4'b0001, 9, 0, -8388608);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.a_bcd  = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      v.b_bcd  = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      v.a_sign = 1'($urandom);
      v.b_sign = 1'($urandom);
      if ($urandom_range(0, 3) != 0) v.op_sel = 4'(1 << $urandom_range(0, 3));
      else                           v.op_sel = 4'($urandom);
      v.lat   = int'($urandom_range(1, 5));
      v.res   = int'($signed(RES_W'($urandom)));
      v.uerr  = ($urandom_range(0, 3) == 0);
      v.stray = 1'b0;
      tbl.push_back(m_expect(v));
    end
    // Leaves a nonzero result behind so the later clears are observable
    add_vec(12'h042, 0, 12'h042, 0, 4'b0001, 1, 4242, 0, 0, 42, 42, 4'b0001, 4, 0, 4242);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset op_a", int'(op_a_o), 0);
    check("reset op_b", int'(op_b_o), 0);
    check("reset unit_start", int'(unit_start_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset exe_done", int'(exe_done_o), 0);
    check("reset result", int'(result_o), 0);
    check("reset err_code", int'(err_code_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    foreach (tbl[i]) run_txn(i, tbl[i]);

    // Selected unit never answers
    begin : tmo_seq
      int dn_cyc = -1, dn_cnt = 0, busy_bad = 0, res_at = -1, err_at = -1;
      for (int k = 0; k <= MAXC; k++) begin
        exe_start_i = (k == 0);
        if (k == 0) begin
          a_bcd_i = 12'h321; a_sign_i = 1'b0; b_bcd_i = 12'h002; b_sign_i = 1'b0;
          op_sel_i = 4'b0100;
        end
        unit_done_i = '0;
`ifdef CAL_EXE_TIMEOUT_EN
        if (k == 12 || k == 13) unit_done_i = 4'b0100;
`endif
        @(negedge clk_i);
        if (exe_done_o) begin
          dn_cnt++;
          if (dn_cyc < 0) begin dn_cyc = k; res_at = int'(result_o); err_at = int'(err_code_o); end
        end
`ifdef CAL_EXE_TIMEOUT_EN
        if (busy_o !== ((k >= 1) && (k <= 3 + TMO))) busy_bad++;
`else
        if (busy_o !== (k >= 1)) busy_bad++;
`endif
        @(posedge clk_i); #1;
      end
      idle_inputs();
`ifdef CAL_EXE_TIMEOUT_EN
      check("timeout exe_done cycle", dn_cyc, 3 + TMO);
      check("timeout exe_done pulses", dn_cnt, 1);
      check("timeout err_code", err_at, 3);
      check("timeout result", res_at, 0);
`else
      check("hang exe_done pulses", dn_cnt, 0);
`endif
      check("timeout busy profile", busy_bad, 0);
    end

    // Reset while waiting on a unit, then a done that must be ignored
    begin : rst_seq
      int dn_cnt = 0, busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        exe_start_i = (k == 0);
        a_bcd_i = 12'h321; a_sign_i = 1'b1; b_bcd_i = 12'h111; b_sign_i = 1'b0;
        op_sel_i = 4'b0001;
        @(posedge clk_i); #1;
      end
      exe_start_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rst busy before reset", int'(busy_o), 1);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      unit_done_i = 4'b0001;
      unit_result_i[0 +: RES_W] = RES_W'(99);
      @(negedge clk_i);
      check("rst busy", int'(busy_o), 0);
      check("rst exe_done", int'(exe_done_o), 0);
      check("rst unit_start", int'(unit_start_o), 0);
      check("rst op_a", int'(op_a_o), 0);
      check("rst op_b", int'(op_b_o), 0);
      check("rst result", int'(result_o), 0);
      check("rst err_code", int'(err_code_o), 0);
      @(posedge clk_i); #1;
      unit_done_i = '0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk_i);
        if (exe_done_o) dn_cnt++;
        if (busy_o) busy_cnt++;
        @(posedge clk_i); #1;
      end
      check("rst no exe_done after", dn_cnt, 0);
      check("rst stays idle", busy_cnt, 0);
    end

    run_txn(100, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
